// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one combinational 32x32 signed multiplier.
// Operands are registered and held SETTLE_CYC cycles before the product is captured.
module mul_share_arbiter #(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = 3,
    parameter int IDW        = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_x,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_x,
    input  logic [63:0]          mul_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [63:0]          rsp_p,
    output logic                 busy
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYC - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] next_ptr;
    logic [CW-1:0]  cnt;
    logic [IDW:0]   idx;
    logic           found;
    logic           accept;

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ))
                idx = idx - (IDW+1)'(NREQ);
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                grant = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == S_IDLE && found)
            req_ready[grant] = 1'b1;
    end

    assign accept   = (state == S_IDLE) && found;
    assign next_ptr = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            mul_a     <= '0;
            mul_x     <= '0;
            rsp_id    <= '0;
            rsp_p     <= '0;
            rsp_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        mul_a  <= req_a[32*grant +: 32];
                        mul_x  <= req_x[32*grant +: 32];
                        rsp_id <= grant;
                        rr_ptr <= next_ptr;
                        cnt    <= CNT_INIT;
                        state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        rsp_p     <= mul_p;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
